// File: rtl/tick_timer_if.sv
// ---------------------------------------------------------------------------
// tick_timer_if
//   Groups the control and status signals of tick_timer into a single bundle.
//   The master side (controller / testbench) drives the requests, and the
//   slave side (the timer) returns the pulse and status.
//
//   Signals:
//     start     master->slave  arm / re-arm the timer
//     interrupt master->slave  cancel a running timer
//     delay     master->slave  requested delay in cycles (0 selects the default)
//     periodic  master->slave  0 one-shot, 1 auto-reload
//     pause     master->slave  hold the count (used only when the timer is
//                              built with TICK_TIMER_PAUSE_EN)
//     out       slave->master  one-cycle expiry pulse
//     busy      slave->master  timer armed and counting
//     count     slave->master  cycles remaining until expiry, 0 when idle
// ---------------------------------------------------------------------------
interface tick_timer_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic             interrupt;
  logic [WIDTH-1:0] delay;
  logic             periodic;
  logic             pause;
  logic             out;
  logic             busy;
  logic [WIDTH-1:0] count;

  modport master (
    output start, interrupt, delay, periodic, pause,
    input  out, busy, count
  );

  modport slave (
    input  start, interrupt, delay, periodic, pause,
    output out, busy, count
  );
endinterface

// File: rtl/tick_timer.sv
// ---------------------------------------------------------------------------
// tick_timer
//   Programmable delay timer for game-event timing (gravity/drop tick etc.).
//   A start request arms a down-counter with the requested delay (or
//   DEFAULT_DELAY when the request is 0). After that many clock edges the
//   timer emits a single-cycle pulse on out. In periodic mode the counter
//   reloads and keeps pulsing until it is cancelled or re-armed.
//
//   Parameters:
//     WIDTH          counter / delay width, maximum delay 2^WIDTH-1
//     DEFAULT_DELAY  delay used when the requested delay is 0
//
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      tick_timer_if.slave: start, interrupt, delay, periodic, pause
//              in; out, busy, count out
//
//   Build option:
//     TICK_TIMER_PAUSE_EN  when defined, pause=1 holds a running count.
//                          When undefined, pause is ignored and no hold
//                          logic is built.
// ---------------------------------------------------------------------------
module tick_timer #(
  parameter int WIDTH         = 6,
  parameter int DEFAULT_DELAY = 33
) (
  input  logic          clk,
  input  logic          reset_n,
  tick_timer_if.slave   bus
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  localparam logic [WIDTH-1:0] DefaultDelayW = WIDTH'(DEFAULT_DELAY);
  localparam logic [WIDTH-1:0] CntOne        = WIDTH'(1);
  localparam logic [WIDTH-1:0] CntZero       = '0;

  logic             state_q,  state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q,   mode_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic             out_q,    out_d;
  logic [WIDTH-1:0] eff_delay;
  logic             hold;

  assign eff_delay = (bus.delay == CntZero) ? DefaultDelayW : bus.delay;

`ifdef TICK_TIMER_PAUSE_EN
  assign hold = bus.pause;
`else
  logic unused_pause;
  assign unused_pause = bus.pause;
  assign hold         = 1'b0;
`endif

  // Next-state logic. start wins over interrupt, and both win over a hold
  // or an expiry falling on the same edge, so a re-arm at the expiry edge
  // swallows the pulse. The counter only ever steps down to 1; the expiry
  // edge then reloads or clears it, so it can never wrap.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    out_d    = 1'b0;

    if (bus.start) begin
      period_d = eff_delay;
      mode_d   = bus.periodic;
      cnt_d    = eff_delay;
      state_d  = RUN;
    end else if (bus.interrupt) begin
      cnt_d   = CntZero;
      state_d = IDLE;
    end else if (state_q == RUN) begin
      if (hold) begin
        cnt_d = cnt_q;
      end else if (cnt_q > CntOne) begin
        cnt_d = cnt_q - CntOne;
      end else begin
        out_d = 1'b1;
        if (mode_q) begin
          cnt_d = period_q;
        end else begin
          cnt_d   = CntZero;
          state_d = IDLE;
        end
      end
    end else begin
      cnt_d = CntZero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      period_q <= CntZero;
      mode_q   <= 1'b0;
      cnt_q    <= CntZero;
      out_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.busy  = state_q;
  assign bus.count = cnt_q;

endmodule

// File: tb/tb_tick_timer.sv
// ---------------------------------------------------------------------------
// tb_tick_timer
//   Self-checking bench for tick_timer (WIDTH=6, DEFAULT_DELAY=33).
//   A vector table covers single-edge behaviour; hand-written sequences
//   cover the long multi-cycle cases (default delay, periodic cancel,
//   retrigger, maximum delay, reset mid-count, pause).
// ---------------------------------------------------------------------------
module tb_tick_timer;

  logic clk;
  logic resetN;
  int   checkCount;
  int   errorCount;

  tick_timer_if #(.WIDTH(6)) bus ();

  tick_timer #(.WIDTH(6), .DEFAULT_DELAY(33)) dut (
    .clk     (clk),
    .reset_n (resetN),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       interrupt;
    logic [5:0] delay;
    logic       periodic;
    logic       expOut;
    logic       expBusy;
    logic [5:0] expCount;
  } vector_t;

  localparam int NumVectors = 21;
  vector_t vectors [NumVectors];

  // Drive one set of inputs, let one rising edge take them, then settle
  // 1 time unit past the edge so outputs are sampled away from it.
  task automatic applyStimulus(input logic s, input logic i, input logic [5:0] d,
                               input logic p, input logic pa);
    bus.start     = s;
    bus.interrupt = i;
    bus.delay     = d;
    bus.periodic  = p;
    bus.pause     = pa;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expOut,
                             input logic expBusy, input logic [5:0] expCount);
    checkCount++;
    if (bus.out !== expOut || bus.busy !== expBusy || bus.count !== expCount) begin
      errorCount++;
      $display("[TB] FAIL %s: out=%0b busy=%0b count=%0d, expected out=%0b busy=%0b count=%0d",
               name, bus.out, bus.busy, bus.count, expOut, expBusy, expCount);
    end
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    resetN        = 1'b0;
    bus.start     = 1'b0;
    bus.interrupt = 1'b0;
    bus.delay     = 6'd0;
    bus.periodic  = 1'b0;
    bus.pause     = 1'b0;

    //                start int delay per  out busy count
    vectors[0]  = '{1'b1, 1'b0, 6'd3, 1'b0, 1'b0, 1'b1, 6'd3};  // arm 3
    vectors[1]  = '{1'b0, 1'b0, 6'd7, 1'b1, 1'b0, 1'b1, 6'd2};  // delay/periodic ignored
    vectors[2]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    vectors[3]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd0};  // expiry
    vectors[4]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0};
    vectors[5]  = '{1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0};  // interrupt in idle
    vectors[6]  = '{1'b1, 1'b1, 6'd2, 1'b0, 1'b0, 1'b1, 6'd2};  // start beats interrupt
    vectors[7]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    vectors[8]  = '{1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, 6'd2};  // start at expiry edge
    vectors[9]  = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    vectors[10] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd0};
    vectors[11] = '{1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b1, 6'd1};  // periodic D=1
    vectors[12] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd1};
    vectors[13] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd1};
    vectors[14] = '{1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0};  // cancel
    vectors[15] = '{1'b1, 1'b0, 6'd2, 1'b1, 1'b0, 1'b1, 6'd2};  // periodic D=2
    vectors[16] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    vectors[17] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd2};
    vectors[18] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd1};
    vectors[19] = '{1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd2};
    vectors[20] = '{1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0};

    // Reset state
    #3;
    checkOutput("reset", 1'b0, 1'b0, 6'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checkOutput("post-reset idle", 1'b0, 1'b0, 6'd0);

    // Vector table
    for (int v = 0; v < NumVectors; v++) begin
      applyStimulus(vectors[v].start, vectors[v].interrupt, vectors[v].delay,
                    vectors[v].periodic, 1'b0);
      checkOutput($sformatf("vec%0d", v), vectors[v].expOut, vectors[v].expBusy,
                  vectors[v].expCount);
    end

    // Default delay: start at E0 with delay 0 -> pulse after E33
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    checkOutput("default E0", 1'b0, 1'b1, 6'd33);
    for (int e = 1; e <= 36; e++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      checkOutput($sformatf("default E%0d", e), (e == 33), (e < 33),
                  (e < 33) ? 6'(33 - e) : 6'd0);
    end

    // Periodic D=5, interrupt at E12
    applyStimulus(1'b1, 1'b0, 6'd5, 1'b1, 1'b0);
    checkOutput("periodic E0", 1'b0, 1'b1, 6'd5);
    for (int e = 1; e <= 18; e++) begin
      applyStimulus(1'b0, (e == 12), 6'd0, 1'b0, 1'b0);
      checkOutput($sformatf("periodic E%0d", e), (e < 12) && (e % 5 == 0), (e < 12),
                  (e < 12) ? 6'(5 - (e % 5)) : 6'd0);
    end

    // Retrigger: delay 10 at E0, delay 4 at E7 -> single pulse after E11
    applyStimulus(1'b1, 1'b0, 6'd10, 1'b0, 1'b0);
    checkOutput("retrig E0", 1'b0, 1'b1, 6'd10);
    for (int e = 1; e <= 15; e++) begin
      applyStimulus((e == 7), 1'b0, (e == 7) ? 6'd4 : 6'd0, 1'b0, 1'b0);
      checkOutput($sformatf("retrig E%0d", e), (e == 11), (e < 11),
                  (e < 7) ? 6'(10 - e) : (e < 11) ? 6'(4 - (e - 7)) : 6'd0);
    end

    // Maximum delay 63
    applyStimulus(1'b1, 1'b0, 6'd63, 1'b0, 1'b0);
    checkOutput("max E0", 1'b0, 1'b1, 6'd63);
    for (int e = 1; e <= 66; e++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      checkOutput($sformatf("max E%0d", e), (e == 63), (e < 63),
                  (e < 63) ? 6'(63 - e) : 6'd0);
    end

    // Delay 1 one-shot
    applyStimulus(1'b1, 1'b0, 6'd1, 1'b0, 1'b0);
    checkOutput("d1 E0", 1'b0, 1'b1, 6'd1);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checkOutput("d1 E1", 1'b1, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checkOutput("d1 E2", 1'b0, 1'b0, 6'd0);

    // Reset mid-count at count=3: clears immediately, no pulse afterwards
    applyStimulus(1'b1, 1'b0, 6'd5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    checkOutput("pre-reset count3", 1'b0, 1'b1, 6'd3);
    resetN = 1'b0;
    #1;
    checkOutput("async reset", 1'b0, 1'b0, 6'd0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
      checkOutput($sformatf("after reset E%0d", e), 1'b0, 1'b0, 6'd0);
    end

    // Pause high on E2..E4 with delay 4
    applyStimulus(1'b1, 1'b0, 6'd4, 1'b0, 1'b0);
    for (int e = 1; e <= 9; e++) begin
      applyStimulus(1'b0, 1'b0, 6'd0, 1'b0, (e >= 2 && e <= 4));
`ifdef TICK_TIMER_PAUSE_EN
      checkOutput($sformatf("pause E%0d", e), (e == 7), (e < 7),
                  (e < 2) ? 6'(4 - e) : (e <= 4) ? 6'd3 : (e < 7) ? 6'(7 - e) : 6'd0);
`else
      checkOutput($sformatf("pause E%0d", e), (e == 4), (e < 4),
                  (e < 4) ? 6'(4 - e) : 6'd0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
# tick_timer

Parametrised programmable delay timer for the game-timing path: a `start` pulse arms a down-counter, and `out` pulses for one cycle exactly DELAY clock edges later. It extends the fixed 33-cycle delay counter with:
- a per-start programmable delay;
- an optional periodic (auto-reload) mode;
- cancel, busy and count status.

It drives the gravity/drop tick and similar game-event timers.

## Interface
Parameters:
- `WIDTH`, 6: counter and delay width in bits; maximum delay 2^WIDTH−1.
- `DEFAULT_DELAY`, 33: delay used when `delay` input is 0.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  arm/re-arm timer; sampled at rising edge.
- `interrupt`  in  1  cancel running timer; sampled at rising edge.
- `delay`  in  WIDTH  requested delay in cycles; captured only when `start` is sampled high.
- `periodic`  in  1  mode select, captured with `delay`: 0 one-shot, 1 auto-reload.
- `pause`  in  1  hold count (active only with `TICK_TIMER_PAUSE_EN`).
- `out`  out  1  registered one-cycle expiry pulse.
- `busy`  out  1  timer armed and counting.
- `count`  out  WIDTH  cycles remaining until expiry; 0 when idle.

## Operation
Registered state:
- `period` (WIDTH): captured delay.
- `mode` (1): captured `periodic`.
- `cnt` (WIDTH).
- `busy`.
- `out`.

States:
- IDLE (`busy`=0).
- RUN (`busy`=1).

Each edge, in priority order:
1. `start`=1 (from any state): `period`←(`delay`==0 ? DEFAULT_DELAY : `delay`); `mode`←`periodic`; `cnt`←that value; `busy`←1; `out`←0. `start` overrides `interrupt` and any expiry due on the same edge; the pending pulse is suppressed.
2. `interrupt`=1 (without `start`): `cnt`←0; `busy`←0; `out`←0; go to IDLE. No effect in IDLE.
3. RUN, `cnt`>1: `cnt`←`cnt`−1; `out`←0.
4. RUN, `cnt`==1: `out`←1.
   - `mode`=0: `cnt`←0, `busy`←0, go to IDLE.
   - `mode`=1: `cnt`←`period`, stay in RUN.
5. IDLE: `out`←0; `cnt` holds 0.

Further rules:
- Changes on `delay` and `periodic` while in RUN are ignored until the next `start`.
- All arithmetic is unsigned WIDTH-bit. `cnt` never wraps: it is never decremented below 1 in RUN.
- `count` = `cnt`. `busy` is the state bit.

## Timing
- Reset (asynchronous, `reset_n`=0): `out`=0, `busy`=0, `count`=0, `period`=0, `mode`=0. Release is synchronous to the next edge.
- Latency: `start` sampled at edge E0 with effective delay D. `busy`=1 from after E0; `out`=1 for the single cycle after edge E_D.
- Effective delay D=1 gives a pulse in the cycle after E1.
- Periodic mode: pulses follow every D edges (after E_D, E_2D, …) until `interrupt` or a new `start`. `busy` stays 1 and `out` is never asserted for two consecutive cycles unless D=1. With D=1, `out` is continuously high.
- Retrigger: `start` in RUN restarts the full delay from that edge.
- Reset asserted mid-count clears everything immediately. No pulse is emitted after reset release.

## Configuration
- `TICK_TIMER_PAUSE_EN` defined:
  - `pause`=1 at an edge in RUN (and no `start`/`interrupt`) holds `cnt` and keeps `out`←0.
  - An expiry due on that edge is deferred until the first edge with `pause`=0.
  - `start` and `interrupt` keep full priority over `pause`.
- Not defined: `pause` input is ignored, no hold logic is synthesised, and behaviour is exactly as in Operation.

## Test plan
- Default delay: `start` at E0 with `delay`=0, `periodic`=0 → `out`=1 only in the cycle after E33; `busy` falls after E33; `count` reads 33 after E0 and 0 after E33.
- Periodic: `start` with `delay`=5, `periodic`=1 → pulses after E5, E10, E15. `interrupt` at E12 → no pulse after E15; `busy`=0 and `count`=0 after E12.
- Retrigger/priority:
  - `delay`=10, `start` at E0 and again at E7 with `delay`=4 → single pulse after E11.
  - `start`+`interrupt` together at E0 → timer runs.
  - `start` at the expiry edge → no pulse, restarts.
- Boundary: `delay`=1 one-shot → pulse after E1. `delay`=63 (WIDTH=6) → pulse after E63. `count` never wraps.
- Reset: `reset_n` low mid-count (`count`=3) → `out`, `busy`, `count` 0 immediately; no pulse after release.
- With `TICK_TIMER_PAUSE_EN`: `delay`=4, `pause` high for edges E2–E4 → pulse after E7. Without the macro, same stimulus → pulse after E4.
